// File: rtl/mem_read_arbiter_n_pkg.sv
// mem_read_arbiter_n_pkg
//   Types and constants shared by the N-channel AXI read front-end:
//   AR FSM state encoding, the width-independent AR attribute bundle,
//   the R beat metadata bundle, AXI burst/response codes and a small
//   helper that classifies RRESP.
package mem_read_arbiter_n_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_ADDR = 1'b1
  } ar_state_e;

  // AR attributes whose widths do not depend on the top-level parameters.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [1:0] lock;
    logic [3:0] cache;
    logic [2:0] prot;
  } axi_ar_req_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       last;
  } axi_r_resp_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_n_rr_arbiter.sv
// rr_arbiter
//   Purely combinational single-grant arbiter.
//   RR_MODE != 0 : first eligible index strictly after ptr_i, wrapping.
//   RR_MODE == 0 : lowest eligible index wins, ptr_i ignored.
// Ports:
//   eligible_i    : per-channel eligibility
//   ptr_i         : index of the most recently served channel
//   grant_o       : one-hot grant (all zero when nothing is eligible)
//   grant_idx_o   : binary index of the granted channel
//   grant_valid_o : a grant was made
module rr_arbiter #(
  parameter int N       = 4,
  parameter int RR_MODE = 1
) (
  input  logic [N-1:0]         eligible_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o,
  output logic                 grant_valid_o
);

  localparam int IW = $clog2(N);

  always_comb begin : p_pick
    int idx;
    idx           = 0;
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (RR_MODE != 0) begin
        // Scan ptr+1, ptr+2, ... so the last winner is considered last.
        idx = int'(ptr_i) + k + 1;
        if (idx >= N) idx = idx - N;
      end else begin
        idx = k;
      end
      if (!grant_valid_o && eligible_i[IW'(idx)]) begin
        grant_valid_o        = 1'b1;
        grant_idx_o          = IW'(idx);
        grant_o[IW'(idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter_n.sv
// mem_read_arbiter_n
//   N-channel AXI4 read front-end. Each channel may have one burst in
//   flight; the channel index is used as ARID and responses are steered
//   back by RID. Requests to a line currently being written are held off.
// Ports:
//   i_clk, i_rst                : clock, asynchronous active-high reset
//   i_req_valid/o_req_ready     : per-channel request / accept pulse
//   i_req_addr/len/size         : packed per-channel AR parameters
//   i_resp_ready                : per-channel R backpressure
//   o_resp_valid/data/last/err  : one-hot beat delivery to requesters
//   o_unexp_rid                 : sticky flag for beats with unknown RID
//   i_wr_busy/i_wr_addr         : in-flight write for line hazard check
//   ar*/r*                      : AXI AR and R channels
module mem_read_arbiter_n
  import mem_read_arbiter_n_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int LINE_OFFSET = 6,
  parameter int RR_MODE     = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_CH-1:0]            i_req_valid,
  output logic [NUM_CH-1:0]            o_req_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_CH*8-1:0]          i_req_len,
  input  logic [NUM_CH*3-1:0]          i_req_size,
  input  logic [NUM_CH-1:0]            i_resp_ready,
  output logic [NUM_CH-1:0]            o_resp_valid,
  output logic [DATA_WIDTH-1:0]        o_resp_data,
  output logic                         o_resp_last,
  output logic                         o_resp_err,
  output logic                         o_unexp_rid,
  input  logic                         i_wr_busy,
  input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
  output logic [ID_WIDTH-1:0]          arid,
  output logic [ADDR_WIDTH-1:0]        araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic [1:0]                   arlock,
  output logic [3:0]                   arcache,
  output logic [2:0]                   arprot,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [ID_WIDTH-1:0]          rid,
  input  logic [DATA_WIDTH-1:0]        rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);

  localparam int IW = $clog2(NUM_CH);

  ar_state_e             state_q;
  logic [NUM_CH-1:0]     outstanding_q, outstanding_d;
  logic [IW-1:0]         rr_ptr_q, gnt_idx_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  axi_ar_req_t           ar_ctl_q;
  logic                  arvalid_q, unexp_q;

  logic [ADDR_WIDTH-1:0] req_addr_a [NUM_CH];
  logic [7:0]            req_len_a  [NUM_CH];
  logic [2:0]            req_size_a [NUM_CH];
  logic [NUM_CH-1:0]     hazard, eligible, grant, rid_sel;
  logic [IW-1:0]         grant_idx;
  logic                  grant_valid, do_grant, rid_hit, r_done;
  axi_r_resp_t           r_meta;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign req_addr_a[gi] = i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_len_a[gi]  = i_req_len[gi*8 +: 8];
      assign req_size_a[gi] = i_req_size[gi*3 +: 3];
      // Block a read that targets the line the write engine is updating.
      assign hazard[gi]  = i_wr_busy &&
                           (req_addr_a[gi][ADDR_WIDTH-1:LINE_OFFSET] ==
                            i_wr_addr[ADDR_WIDTH-1:LINE_OFFSET]);
      assign rid_sel[gi] = (rid == ID_WIDTH'(gi));
    end
  endgenerate

  assign eligible = i_req_valid & ~outstanding_q & ~hazard;

  rr_arbiter #(
    .N       (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .eligible_i    (eligible),
    .ptr_i         (rr_ptr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign do_grant    = (state_q == AR_IDLE) && grant_valid && !i_rst;
  assign o_req_ready = do_grant ? grant : '0;

  // R path: a beat belongs to a requester only if its RID maps to a
  // channel with a burst in flight; anything else is swallowed.
  assign r_meta  = '{resp: rresp, last: rlast};
  assign rid_hit = |(rid_sel & outstanding_q);

  always_comb begin
    o_resp_valid = '0;
    o_resp_data  = '0;
    o_resp_last  = 1'b0;
    o_resp_err   = 1'b0;
    rready       = 1'b0;
    if (!i_rst) begin
      if (rid_hit) begin
        o_resp_valid = rid_sel & {NUM_CH{rvalid}};
        o_resp_data  = rdata;
        o_resp_last  = r_meta.last;
        o_resp_err   = resp_is_err(r_meta.resp);
        rready       = |(rid_sel & i_resp_ready);
      end else begin
        rready = 1'b1;
      end
    end
  end

  assign r_done = rvalid && rready && r_meta.last && rid_hit;

  // A granted channel is never outstanding, so set and clear never collide.
  assign outstanding_d = (outstanding_q | (do_grant ? grant : '0)) &
                         ~(r_done ? rid_sel : '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= AR_IDLE;
      outstanding_q <= '0;
      rr_ptr_q      <= IW'(NUM_CH - 1);
      gnt_idx_q     <= '0;
      arid_q        <= '0;
      araddr_q      <= '0;
      ar_ctl_q      <= '0;
      arvalid_q     <= 1'b0;
      unexp_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (rvalid && !rid_hit) unexp_q <= 1'b1;
      case (state_q)
        AR_IDLE: begin
          if (do_grant) begin
            gnt_idx_q <= grant_idx;
            arid_q    <= ID_WIDTH'(grant_idx);
            araddr_q  <= req_addr_a[grant_idx];
            ar_ctl_q  <= '{len: req_len_a[grant_idx], size: req_size_a[grant_idx],
                           burst: BURST_INCR, lock: 2'b00, cache: 4'h0, prot: 3'h0};
            arvalid_q <= 1'b1;
            state_q   <= AR_ADDR;
          end
        end
        AR_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            if (RR_MODE != 0) rr_ptr_q <= gnt_idx_q;
            state_q   <= AR_IDLE;
          end
        end
        default: state_q <= AR_IDLE;
      endcase
    end
  end

  assign arid        = arid_q;
  assign araddr      = araddr_q;
  assign arlen       = ar_ctl_q.len;
  assign arsize      = ar_ctl_q.size;
  assign arburst     = ar_ctl_q.burst;
  assign arlock      = ar_ctl_q.lock;
  assign arcache     = ar_ctl_q.cache;
  assign arprot      = ar_ctl_q.prot;
  assign arvalid     = arvalid_q;
  assign o_unexp_rid = unexp_q;

endmodule

// File: tb/tb_mem_read_arbiter_n.sv
module tb_mem_read_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0, rst1;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [31:0]  req_len;
  logic [11:0]  req_size;
  logic [3:0]   resp_ready;
  logic         wr_busy;
  logic [31:0]  wr_addr;
  logic         arready_s;
  logic [3:0]   rid_s;
  logic [31:0]  rdata_s;
  logic [1:0]   rresp_s;
  logic         rlast_s, rvalid_s;

  // DUT0: round-robin
  logic [3:0]  req_ready0, resp_valid0;
  logic [31:0] resp_data0, araddr0;
  logic        resp_last0, resp_err0, unexp0, arvalid0, rready0;
  logic [3:0]  arid0, arcache0;
  logic [7:0]  arlen0;
  logic [2:0]  arsize0, arprot0;
  logic [1:0]  arburst0, arlock0;
  // DUT1: fixed priority
  logic [3:0]  req_ready1, resp_valid1;
  logic [31:0] resp_data1, araddr1;
  logic        resp_last1, resp_err1, unexp1, arvalid1, rready1;
  logic [3:0]  arid1, arcache1;
  logic [7:0]  arlen1;
  logic [2:0]  arsize1, arprot1;
  logic [1:0]  arburst1, arlock1;

  mem_read_arbiter_n #(.NUM_CH(4), .RR_MODE(1)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_req_valid(req_valid), .o_req_ready(req_ready0),
    .i_req_addr(req_addr), .i_req_len(req_len), .i_req_size(req_size),
    .i_resp_ready(resp_ready), .o_resp_valid(resp_valid0), .o_resp_data(resp_data0),
    .o_resp_last(resp_last0), .o_resp_err(resp_err0), .o_unexp_rid(unexp0),
    .i_wr_busy(wr_busy), .i_wr_addr(wr_addr),
    .arid(arid0), .araddr(araddr0), .arlen(arlen0), .arsize(arsize0), .arburst(arburst0),
    .arlock(arlock0), .arcache(arcache0), .arprot(arprot0), .arvalid(arvalid0),
    .arready(arready_s), .rid(rid_s), .rdata(rdata_s), .rresp(rresp_s), .rlast(rlast_s),
    .rvalid(rvalid_s), .rready(rready0));

  mem_read_arbiter_n #(.NUM_CH(4), .RR_MODE(0)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_req_valid(req_valid), .o_req_ready(req_ready1),
    .i_req_addr(req_addr), .i_req_len(req_len), .i_req_size(req_size),
    .i_resp_ready(resp_ready), .o_resp_valid(resp_valid1), .o_resp_data(resp_data1),
    .o_resp_last(resp_last1), .o_resp_err(resp_err1), .o_unexp_rid(unexp1),
    .i_wr_busy(wr_busy), .i_wr_addr(wr_addr),
    .arid(arid1), .araddr(araddr1), .arlen(arlen1), .arsize(arsize1), .arburst(arburst1),
    .arlock(arlock1), .arcache(arcache1), .arprot(arprot1), .arvalid(arvalid1),
    .arready(arready_s), .rid(rid_s), .rdata(rdata_s), .rresp(rresp_s), .rlast(rlast_s),
    .rvalid(rvalid_s), .rready(rready1));

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;
  typedef struct {
    logic [3:0]  oh;
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  logic [3:0] exp_gnt_q[$];
  logic [3:0] exp_gnt1_q[$];
  ar_t        exp_ar_q[$];
  beat_t      exp_beat_q[$];
  logic [3:0] gnt_cap = 4'h0;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endfunction

  function automatic void extra(string name, logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, expected no event", name, act);
  endfunction

  // Monitor: pops expected events whenever a DUT presents one.
  always @(negedge clk) begin
    gnt_cap = req_ready0 | req_ready1;
    if (!rst0) begin
      if (req_ready0 != 4'h0) begin
        if (exp_gnt_q.size() == 0) extra("gnt", req_ready0);
        else check("gnt", req_ready0, exp_gnt_q.pop_front());
      end
      if (arvalid0 && arready_s) begin
        if (exp_ar_q.size() == 0) extra("ar", araddr0);
        else begin
          ar_t a;
          a = exp_ar_q.pop_front();
          check("ar_id", arid0, a.id);
          check("ar_addr", araddr0, a.addr);
          check("ar_len", arlen0, a.len);
          check("ar_size", arsize0, a.size);
          check("ar_attr", {arburst0, arlock0, arcache0, arprot0}, {2'b01, 2'b00, 4'h0, 3'h0});
        end
      end
      if (rvalid_s && rready0 && resp_valid0 != 4'h0) begin
        if (exp_beat_q.size() == 0) extra("beat", resp_valid0);
        else begin
          beat_t b;
          b = exp_beat_q.pop_front();
          check("beat_valid", resp_valid0, b.oh);
          check("beat_data", resp_data0, b.data);
          check("beat_last_err", {resp_last0, resp_err0}, {b.last, b.err});
        end
      end
    end
    if (!rst1 && req_ready1 != 4'h0) begin
      if (exp_gnt1_q.size() == 0) extra("gnt_fixed", req_ready1);
      else check("gnt_fixed", req_ready1, exp_gnt1_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~gnt_cap;
  endtask

  task automatic req(input int ch, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    req_valid[ch]       = 1'b1;
    req_addr[ch*32 +: 32] = a;
    req_len[ch*8 +: 8]  = l;
    req_size[ch*3 +: 3] = s;
  endtask

  task automatic expect_grant(input int ch, input logic [31:0] a, input logic [7:0] l,
                              input logic [2:0] s, input bit with_ar);
    logic [3:0] oh;
    ar_t x;
    oh = 4'b0001 << ch;
    exp_gnt_q.push_back(oh);
    if (with_ar) begin
      x.id = 4'(ch); x.addr = a; x.len = l; x.size = s;
      exp_ar_q.push_back(x);
    end
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic l,
                      input logic [1:0] rsp, input logic [3:0] exp_oh, input logic exp_err);
    beat_t b;
    rvalid_s = 1'b1; rid_s = id; rdata_s = d; rlast_s = l; rresp_s = rsp;
    if (exp_oh != 4'h0) begin
      b.oh = exp_oh; b.data = d; b.last = l; b.err = exp_err;
      exp_beat_q.push_back(b);
    end
  endtask

  task automatic queues_empty();
    check("q_gnt_empty", exp_gnt_q.size(), 0);
    check("q_ar_empty", exp_ar_q.size(), 0);
    check("q_beat_empty", exp_beat_q.size(), 0);
    check("q_gnt1_empty", exp_gnt1_q.size(), 0);
  endtask

  task automatic reset_dut0();
    queues_empty();
    rst0 = 1'b1; req_valid = '0; rvalid_s = 1'b0; wr_busy = 1'b0;
    arready_s = 1'b1; resp_ready = 4'hF;
    tick(); tick();
    rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    req_valid = 4'hF; req_addr = '0; req_len = '0; req_size = '0;
    resp_ready = 4'hF; wr_busy = 1'b0; wr_addr = '0; arready_s = 1'b1;
    rid_s = 4'd2; rdata_s = '0; rresp_s = 2'b00; rlast_s = 1'b0; rvalid_s = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready0, 4'h0);
    check("rst_rready", rready0, 1'b0);
    check("rst_resp_valid", resp_valid0, 4'h0);
    check("rst_arvalid", arvalid0, 1'b0);
    check("rst_ar_fields", {arid0, araddr0, arlen0, arsize0, arburst0}, '0);
    check("rst_unexp", unexp0, 1'b0);
    req_valid = '0; rvalid_s = 1'b0;
    rst0 = 1'b0;

    // 1: single 16-beat burst on ch2, re-grant one cycle after rlast
    req(2, 32'h1FC0_0040, 8'd15, 3'd2);
    expect_grant(2, 32'h1FC0_0040, 8'd15, 3'd2, 1);
    @(negedge clk); check("t1_arvalid_T", arvalid0, 1'b0);
    tick();
    @(negedge clk); check("t1_arvalid_T1", arvalid0, 1'b1);
    tick();
    for (int k = 0; k < 16; k++) begin
      beat(4'd2, 32'hA000_0000 + k, k == 15, 2'b00, 4'b0100, 1'b0);
      if (k == 15) begin
        req(2, 32'h1FC0_0080, 8'd0, 3'd2);
        @(negedge clk); check("t1_no_regrant_at_rlast", req_ready0, 4'h0);
      end
      tick();
    end
    rvalid_s = 1'b0;
    expect_grant(2, 32'h1FC0_0080, 8'd0, 3'd2, 1);
    tick(); tick();
    reset_dut0();

    // 2a: round-robin order 0,1,2,3 then rotation past the last winner
    for (int c = 0; c < 4; c++) begin
      req(c, 32'h100 * (c + 1), 8'd0, 3'd2);
      expect_grant(c, 32'h100 * (c + 1), 8'd0, 3'd2, 1);
    end
    repeat (8) tick();
    beat(4'd0, 32'h0000_0C00, 1'b1, 2'b00, 4'b0001, 1'b0); tick();
    beat(4'd2, 32'h0000_0C02, 1'b1, 2'b00, 4'b0100, 1'b0); tick();
    rvalid_s = 1'b0;
    req(0, 32'h500, 8'd0, 3'd2);
    expect_grant(0, 32'h500, 8'd0, 3'd2, 1);
    tick(); tick();
    beat(4'd0, 32'h0000_0C10, 1'b1, 2'b00, 4'b0001, 1'b0); tick();
    rvalid_s = 1'b0;
    req(0, 32'h600, 8'd0, 3'd2);
    req(2, 32'h700, 8'd0, 3'd2);
    expect_grant(2, 32'h700, 8'd0, 3'd2, 1);
    expect_grant(0, 32'h600, 8'd0, 3'd2, 1);
    repeat (4) tick();
    queues_empty();

    // 2b: fixed priority on DUT1, ch0 wins whenever eligible
    rst0 = 1'b1; req_valid = '0;
    tick();
    rst1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req(c, 32'h100 * (c + 1), 8'd0, 3'd2);
      exp_gnt1_q.push_back(4'b0001 << c);
    end
    repeat (8) tick();
    beat(4'd0, 32'h0, 1'b1, 2'b00, 4'h0, 1'b0); tick();
    beat(4'd2, 32'h0, 1'b1, 2'b00, 4'h0, 1'b0); tick();
    rvalid_s = 1'b0;
    req(2, 32'h700, 8'd0, 3'd2);
    req(0, 32'h600, 8'd0, 3'd2);
    exp_gnt1_q.push_back(4'b0001);
    exp_gnt1_q.push_back(4'b0100);
    repeat (4) tick();
    rst1 = 1'b1;
    reset_dut0();

    // 3: interleaved beats for ch3/ch1 with ch3 backpressured
    req(1, 32'h1100, 8'd1, 3'd2);
    req(3, 32'h3300, 8'd1, 3'd2);
    expect_grant(1, 32'h1100, 8'd1, 3'd2, 1);
    expect_grant(3, 32'h3300, 8'd1, 3'd2, 1);
    repeat (4) tick();
    resp_ready = 4'b0111;
    beat(4'd3, 32'h31, 1'b0, 2'b00, 4'h0, 1'b0);
    @(negedge clk);
    check("t3_rready_stall1", rready0, 1'b0);
    check("t3_valid_stall1", resp_valid0, 4'b1000);
    tick();
    @(negedge clk); check("t3_rready_stall2", rready0, 1'b0);
    tick();
    resp_ready = 4'hF;
    beat(4'd3, 32'h31, 1'b0, 2'b00, 4'b1000, 1'b0); tick();
    resp_ready = 4'b0111;
    beat(4'd1, 32'h11, 1'b0, 2'b00, 4'b0010, 1'b0);
    @(negedge clk); check("t3_rready_rid1", rready0, 1'b1);
    tick();
    resp_ready = 4'hF;
    beat(4'd3, 32'h32, 1'b1, 2'b00, 4'b1000, 1'b0); tick();
    beat(4'd1, 32'h12, 1'b1, 2'b00, 4'b0010, 1'b0); tick();
    rvalid_s = 1'b0;
    req(1, 32'h1140, 8'd0, 3'd2);
    req(3, 32'h3340, 8'd0, 3'd2);
    expect_grant(1, 32'h1140, 8'd0, 3'd2, 1);
    expect_grant(3, 32'h3340, 8'd0, 3'd2, 1);
    repeat (4) tick();
    reset_dut0();

    // 4: write line hazard on ch0, ch1 unaffected
    wr_busy = 1'b1; wr_addr = 32'h0000_1048;
    req(0, 32'h0000_1070, 8'd0, 3'd2);
    req(1, 32'h0000_2000, 8'd0, 3'd2);
    expect_grant(1, 32'h0000_2000, 8'd0, 3'd2, 1);
    tick(); tick();
    @(negedge clk); check("t4_hazard_block_a", req_ready0, 4'h0);
    tick();
    @(negedge clk); check("t4_hazard_block_b", req_ready0, 4'h0);
    tick();
    wr_busy = 1'b0;
    expect_grant(0, 32'h0000_1070, 8'd0, 3'd2, 1);
    tick(); tick();
    reset_dut0();

    // 5: unexpected RID and error beat
    beat(4'd5, 32'hDEAD_BEEF, 1'b1, 2'b00, 4'h0, 1'b0);
    @(negedge clk);
    check("t5_unexp_rready", rready0, 1'b1);
    check("t5_unexp_valid", resp_valid0, 4'h0);
    check("t5_unexp_before", unexp0, 1'b0);
    tick();
    rvalid_s = 1'b0;
    @(negedge clk); check("t5_unexp_set", unexp0, 1'b1);
    req(0, 32'h40, 8'd1, 3'd2);
    expect_grant(0, 32'h40, 8'd1, 3'd2, 1);
    tick(); tick();
    beat(4'd0, 32'hE0, 1'b0, 2'b10, 4'b0001, 1'b1); tick();
    beat(4'd0, 32'hE1, 1'b1, 2'b00, 4'b0001, 1'b0); tick();
    rvalid_s = 1'b0;
    @(negedge clk); check("t5_unexp_sticky", unexp0, 1'b1);
    reset_dut0();
    check("t5_unexp_cleared", unexp0, 1'b0);

    // 6: asynchronous reset mid-transaction
    req(1, 32'h1000, 8'd3, 3'd2);
    req(2, 32'h2000, 8'd3, 3'd2);
    expect_grant(1, 32'h1000, 8'd3, 3'd2, 1);
    expect_grant(2, 32'h2000, 8'd3, 3'd2, 0);
    tick(); tick();
    arready_s = 1'b0;
    tick();
    @(negedge clk); check("t6_arvalid_held", arvalid0, 1'b1);
    tick();
    rvalid_s = 1'b1; rid_s = 4'd1; rlast_s = 1'b0;
    rst0 = 1'b1;
    #1;
    check("t6_async_arvalid", arvalid0, 1'b0);
    check("t6_async_araddr", araddr0, 32'h0);
    check("t6_async_rready", rready0, 1'b0);
    check("t6_async_resp_valid", resp_valid0, 4'h0);
    rvalid_s = 1'b0;
    tick();
    queues_empty();
    rst0 = 1'b0; arready_s = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req(c, 32'h4000 + 32'h40 * c, 8'd0, 3'd2);
      expect_grant(c, 32'h4000 + 32'h40 * c, 8'd0, 3'd2, 1);
    end
    repeat (8) tick();

    queues_empty();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter_n.md
Name: mem_read_arbiter_n

Overview:
- Parametrised N-channel AXI4 read front-end that replaces the fixed two-source (instruction/data, cached/uncached) read arbitration.
- Sits between the requesters (icache, dcache, uncached instruction/data ports, and future prefetch/DMA clients) and the single AXI AR/R interface.
- Uses the channel index as ARID, so up to one burst per channel can be outstanding concurrently. Responses are routed back by RID.
- Adds round-robin or fixed priority, per-channel R backpressure, read-after-write line hazard blocking and error reporting.

Parameters:
- NUM_CH, 4, number of requester channels (2..2**ID_WIDTH).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, R data width.
- ID_WIDTH, 4, AXI ID width.
- LINE_OFFSET, 6, log2 line bytes used for hazard compare.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  NUM_CH  per-channel read request.
- o_req_ready  out  NUM_CH  grant/accept pulse.
- i_req_addr  in  NUM_CH*ADDR_WIDTH  start address, channel i at slice i.
- i_req_len  in  NUM_CH*8  beats-1 (ARLEN encoding).
- i_req_size  in  NUM_CH*3  ARSIZE.
- i_resp_ready  in  NUM_CH  channel can take an R beat.
- o_resp_valid  out  NUM_CH  one-hot beat valid.
- o_resp_data  out  DATA_WIDTH  shared beat data.
- o_resp_last  out  1  last beat.
- o_resp_err  out  1  RRESP != OKAY on this beat.
- o_unexp_rid  out  1  sticky: R beat seen with an RID having no outstanding request.
- i_wr_busy  in  1  write engine holds an in-flight write.
- i_wr_addr  in  ADDR_WIDTH  address of that write.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI AR fields, widths ID_WIDTH/ADDR_WIDTH/8/3/2/2/4/3/1.
- arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1.
- rready  out  1.

Behaviour:
- Reset: arvalid=0, all AR fields 0, outstanding[]=0, rr pointer=NUM_CH-1 (ch0 first), o_unexp_rid=0, o_req_ready=0. rready and o_resp_* are driven 0 while i_rst is high.
- Eligibility of channel i = i_req_valid[i] & ~outstanding[i] & ~hazard[i].
  - hazard[i] = i_wr_busy & (i_req_addr[i][ADDR_WIDTH-1:LINE_OFFSET] == i_wr_addr[ADDR_WIDTH-1:LINE_OFFSET]).
- AR FSM has two states:
  - IDLE: if any channel is eligible, grant one. o_req_ready[g]=1 combinationally in that cycle. Register araddr/arlen/arsize/arid=g, arburst=INCR(01), arlock=0, arcache=0, arprot=0. Set outstanding[g]. Go to ADDR with arvalid=1 from the next cycle.
  - ADDR: hold arvalid and all AR fields stable until arready. On handshake, clear arvalid, update rr pointer to g (RR_MODE=1) and return to IDLE. No new grant is made in the cycle the handshake occurs.
- Throughput is therefore one AR every 2 cycles with arready tied high.
- Arbitration: RR_MODE=1 grants the first eligible index strictly after the pointer, wrapping modulo NUM_CH. RR_MODE=0 grants the lowest eligible index.
- Requester must hold valid/addr/len/size stable until o_req_ready.
- R path is combinational, zero latency:
  - If rid < NUM_CH and outstanding[rid]: o_resp_valid[rid]=rvalid, data/last from R, err=(rresp!=0), rready=i_resp_ready[rid].
  - Otherwise: rready=1, beat dropped, o_unexp_rid set on rvalid (cleared only by reset).
- outstanding[rid] clears on rvalid&rready&rlast. The channel becomes eligible the following cycle; there is no same-cycle bypass.
- An error beat still counts toward the burst; the burst completes normally on rlast.
- Reset mid-burst clears all state. System reset must also reset the AXI slave.

Decomposition:
- Shared package (existing def package): axi_ar_req / axi_r_resp structs, AXI burst/resp constants (BURST_INCR=2'b01, RESP_OKAY=2'b00).
- One sub-module: rr_arbiter #(N, RR_MODE). Inputs: eligible vector, pointer. Output: one-hot grant plus index. Purely combinational.

Test Plan:
1. NUM_CH=4, ch2 requests addr 0x1FC0_0040 len 15 size 2, arready=1 -> o_req_ready[2] at T, arvalid at T+1 with arid=2, araddr=0x1FC00040, arlen=15, arburst=01. 16 R beats with rid=2 give o_resp_valid=4'b0100 and o_resp_last on beat 16. ch2 is re-grantable at rlast+1.
2. All 4 channels request continuously, RR_MODE=1, arready=1 -> grant order 0,1,2,3. With RR_MODE=0 and ch0 re-requesting after completion -> ch0 always wins over 1..3 when eligible.
3. ch1 and ch3 outstanding, R beats interleaved rid=3,1,3,1 with i_resp_ready[3]=0 for 2 cycles -> rready low only on rid=3 beats. Data is delivered to the correct one-hot valid and no beat is lost.
4. i_wr_busy=1, i_wr_addr=0x0000_1048, ch0 requests 0x0000_1070 -> no grant while busy. Grant occurs the cycle after i_wr_busy falls. ch1 requesting 0x0000_2000 is granted meanwhile.
5. R beat rid=5 (no outstanding) -> rready=1, no o_resp_valid, o_unexp_rid=1 until reset. Beat rresp=2'b10 -> o_resp_err=1 on that beat only.
6. Assert i_rst while arvalid=1 and bursts are outstanding -> arvalid=0 and outstanding=0 immediately, without a clock edge. After release, ch0 is granted first.
